// File: rtl/y_change_sequencer.sv
// y_change_sequencer
//   Drives the Y-matrix address decoder for the change-in-Y flow. Row numbers
//   from the change.txt reader are queued in a small FIFO. For each entry the
//   controller issues one read on the shared 256-bit Y-memory port, steps the
//   decoder through its two-cycle lookup, captures the resulting line-address
//   pair and presents it downstream on a valid/ready handshake.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-low reset
//   chg_valid/chg_row   change entry in; chg_ready = FIFO can accept
//   mem_rd_en/addr      Y memory read strobe and line address (row >> 4)
//   mem_rd_data         Y memory data, valid the cycle after mem_rd_en
//   dec_enable/dec_row  decoder control (registered)
//   dec_row_data        combinational pass-through of mem_rd_data
//   dec_addr1/2         decoder address results
//   out_valid/addr1/2   captured address pair; out_ready = consumer accepts
//   busy                FSM active or FIFO holds entries
//
// Optional build macro
//   Y_SEQ_STATS_EN : adds 16-bit wrapping counters done_cnt (EMIT handshakes)
//                    and drop_cnt (accepted all-ones sentinel rows).
module y_change_sequencer #(
    parameter int DEPTH  = 4,
    parameter int ROW_W  = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              chg_valid,
    input  logic [ROW_W-1:0]  chg_row,
    output logic              chg_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [255:0]      mem_rd_data,
    output logic              dec_enable,
    output logic [ROW_W-1:0]  dec_row,
    output logic [255:0]      dec_row_data,
    input  logic [ADDR_W-1:0] dec_addr1,
    input  logic [ADDR_W-1:0] dec_addr2,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr1,
    output logic [ADDR_W-1:0] out_addr2,
    input  logic              out_ready,
    output logic              busy
`ifdef Y_SEQ_STATS_EN
    ,
    output logic [15:0]       done_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_CAPT,
        S_EMIT
    } state_t;

    state_t             r_state;
    logic [ROW_W-1:0]   r_cur_row;
    logic               r_mem_rd_en;
    logic [ADDR_W-1:0]  r_mem_rd_addr;
    logic               r_dec_enable;
    logic [ROW_W-1:0]   r_dec_row;
    logic               r_out_valid;
    logic [ADDR_W-1:0]  r_out_addr1;
    logic [ADDR_W-1:0]  r_out_addr2;
    logic               r_busy;

    // ---------------- change-entry FIFO ----------------
    logic [ROW_W-1:0]   r_fifo [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_sentinel;
    logic               w_accept;
    logic               w_push;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ROW_W-1:0]   w_head;
    logic               w_to_idle;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_head     = r_fifo[r_rd_ptr];
    // The FSM only ever pops from IDLE or from a completed EMIT handshake.
    assign w_pop      = !w_empty && ((r_state == S_IDLE) ||
                                     (r_state == S_EMIT && out_ready));
    assign chg_ready  = !w_full || w_pop;
    assign w_sentinel = (chg_row == '1);
    assign w_accept   = chg_valid && chg_ready;
    // A sentinel completes the handshake but is never queued.
    assign w_push     = w_accept && !w_sentinel;
    assign w_cnt_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // FSM lands in IDLE next cycle only if nothing is left to pop now.
    assign w_to_idle  = w_empty && ((r_state == S_IDLE) ||
                                    (r_state == S_EMIT && out_ready));

    always_ff @(posedge clock) begin
        if (reset && w_push)
            r_fifo[r_wr_ptr] <= chg_row;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_cnt_nxt;
        end
    end

    // ---------------- sequencing FSM ----------------
    // Outputs are loaded on the transition so they line up with the state
    // being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cur_row     <= '1;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_dec_enable  <= 1'b0;
            r_dec_row     <= '1;
            r_out_valid   <= 1'b0;
            r_out_addr1   <= '1;
            r_out_addr2   <= '1;
            r_busy        <= 1'b0;
        end else begin
            r_mem_rd_en <= 1'b0;
            r_busy      <= !w_to_idle || (w_cnt_nxt != '0);
            case (r_state)
                S_IDLE: begin
                    r_dec_enable <= 1'b0;
                    r_dec_row    <= '1;
                    if (w_pop) begin
                        r_cur_row     <= w_head;
                        r_mem_rd_en   <= 1'b1;
                        r_mem_rd_addr <= ADDR_W'(w_head >> 4);
                        r_dec_row     <= w_head;
                        r_dec_enable  <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Read data lands during DATA; decoder stays enabled.
                    r_dec_row    <= r_cur_row;
                    r_dec_enable <= 1'b1;
                    r_state      <= S_DATA;
                end
                S_DATA: begin
                    r_dec_row    <= r_cur_row;
                    r_dec_enable <= 1'b0;
                    r_state      <= S_CAPT;
                end
                S_CAPT: begin
                    r_out_addr1  <= dec_addr1;
                    r_out_addr2  <= dec_addr2;
                    r_out_valid  <= 1'b1;
                    r_dec_row    <= '1;
                    r_state      <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_pop) begin
                            r_cur_row     <= w_head;
                            r_mem_rd_en   <= 1'b1;
                            r_mem_rd_addr <= ADDR_W'(w_head >> 4);
                            r_dec_row     <= w_head;
                            r_dec_enable  <= 1'b1;
                            r_state       <= S_REQ;
                        end else begin
                            r_state       <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_en    = r_mem_rd_en;
    assign mem_rd_addr  = r_mem_rd_addr;
    assign dec_enable   = r_dec_enable;
    assign dec_row      = r_dec_row;
    assign dec_row_data = mem_rd_data;
    assign out_valid    = r_out_valid;
    assign out_addr1    = r_out_addr1;
    assign out_addr2    = r_out_addr2;
    assign busy         = r_busy;

`ifdef Y_SEQ_STATS_EN
    logic [15:0] r_done_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_done_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (r_state == S_EMIT && out_ready) r_done_cnt <= r_done_cnt + 16'd1;
            if (w_accept && w_sentinel)         r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign done_cnt = r_done_cnt;
    assign drop_cnt = r_drop_cnt;
`endif

endmodule
